// File: rtl/cnn_pkg.sv
// cnn_pkg: shared state encoding, batch geometry defaults and timeout class code for the CNN frame sequencer
package cnn_pkg;
  localparam int IMG_PIXELS_DEF = 784;
  localparam int NUM_IMAGES_DEF = 100;
  localparam int ADDR_W_DEF = $clog2(NUM_IMAGES_DEF * IMG_PIXELS_DEF);
  localparam logic [3:0] TIMEOUT_CLASS = 4'hF;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_STREAM,
    S_WAIT,
    S_RECORD,
    S_DONE
  } state_t;
endpackage

// File: rtl/cnn_pixel_streamer.sv
// cnn_pixel_streamer: issues one image's pixel reads from base_addr (start pulse), aligns read data to a 2-cycle valid pipe, flags last_issued and draining
module cnn_pixel_streamer #(
  parameter int IMG_PIXELS = 784,
  parameter int ADDR_W = 17,
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  output logic              last_issued,
  output logic              draining
);
  logic [CNT_W-1:0] pix_cnt;
  logic             rd_q;
  assign last_issued = mem_rd_en && pix_cnt == CNT_W'(IMG_PIXELS - 1);
  assign draining = rd_q || pixel_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      mem_rd_en <= 1'b0;
      pix_cnt <= '0;
      rd_q <= 1'b0;
      pixel <= '0;
      pixel_valid <= 1'b0;
    end else begin
      rd_q <= mem_rd_en;
      pixel_valid <= rd_q;
      if (rd_q) pixel <= mem_rdata;
      if (start) begin
        mem_rd_en <= 1'b1;
        mem_addr <= base_addr;
        pix_cnt <= '0;
      end else if (last_issued) begin
        mem_rd_en <= 1'b0;
      end else if (mem_rd_en) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: runs the CNN core over a batch (reset core, stream pixels, await/score decision) and reports per-image results, correct count and sticky timeout
module cnn_frame_sequencer
  import cnn_pkg::*;
#(
  parameter int IMG_PIXELS = IMG_PIXELS_DEF,
  parameter int NUM_IMAGES = NUM_IMAGES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W = 7,
  parameter int CNT_W = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic [IDX_W-1:0]  label_addr,
  input  logic [3:0]        label_rdata,
  output logic              cnn_rst,
  output logic [7:0]        cnn_pixel,
  output logic              cnn_pixel_valid,
  input  logic [3:0]        cnn_decision,
  input  logic              cnn_valid,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [IDX_W-1:0]  result_index,
  output logic [3:0]        result_class,
  output logic              result_correct,
  output logic [IDX_W-1:0]  correct_count,
  output logic              timeout_err
);
  localparam int TMR_W = $clog2(TIMEOUT);
  state_t            state, state_n;
  logic [IDX_W-1:0]  img_idx;
  logic [ADDR_W-1:0] base_addr;
  logic [TMR_W-1:0]  timer;
  logic              last_issued, draining, accept, tmr_end, last_img, launch;
  cnn_pixel_streamer #(
    .IMG_PIXELS(IMG_PIXELS),
    .ADDR_W(ADDR_W),
    .CNT_W(CNT_W)
  ) u_streamer (
    .clk(clk),
    .rst(rst),
    .start(state == S_CRST),
    .base_addr(base_addr),
    .mem_rdata(mem_rdata),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .pixel(cnn_pixel),
    .pixel_valid(cnn_pixel_valid),
    .last_issued(last_issued),
    .draining(draining)
  );
  assign label_addr = img_idx;
  assign result_index = img_idx;
  always_comb begin
    state_n = state;
    launch = start && (state == S_IDLE || state == S_DONE);
    accept = state == S_WAIT && cnn_valid && !draining;
    tmr_end = state == S_WAIT && timer == TMR_W'(TIMEOUT - 1);
    last_img = img_idx == IDX_W'(NUM_IMAGES - 1);
    busy = !(state == S_IDLE || state == S_DONE);
    done = state == S_DONE;
    cnn_rst = rst || state == S_CRST;
    result_valid = state == S_RECORD;
    case (state)
      S_IDLE, S_DONE: state_n = start ? S_CRST : state;
      S_CRST:         state_n = S_STREAM;
      S_STREAM:       state_n = last_issued ? S_WAIT : S_STREAM;
      S_WAIT:         state_n = (accept || tmr_end) ? S_RECORD : S_WAIT;
      S_RECORD:       state_n = last_img ? S_DONE : S_CRST;
      default:        state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      img_idx <= '0;
      base_addr <= '0;
      timer <= '0;
      result_class <= '0;
      result_correct <= 1'b0;
      correct_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      timer <= state == S_WAIT ? timer + TMR_W'(1) : '0;
      if (launch) begin
        img_idx <= '0;
        base_addr <= '0;
        correct_count <= '0;
        timeout_err <= 1'b0;
        result_class <= '0;
        result_correct <= 1'b0;
      end
      if (accept) begin
        result_class <= cnn_decision;
        result_correct <= cnn_decision == label_rdata;
      end else if (tmr_end) begin
        result_class <= TIMEOUT_CLASS;
        result_correct <= 1'b0;
        timeout_err <= 1'b1;
      end
      if (state == S_RECORD) begin
        correct_count <= correct_count + IDX_W'(result_correct);
        if (!last_img) begin
          img_idx <= img_idx + IDX_W'(1);
          base_addr <= base_addr + ADDR_W'(IMG_PIXELS);
        end
      end
    end
  end
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: table-driven batches against pixel/label memory and core models, plus restart, timeout and mid-batch reset sequences
module tb_cnn_frame_sequencer;
  localparam int IMG = 784;
  localparam int NIMG = 3;
  localparam int AW = 17;
  localparam int IW = 7;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] mem_addr;
  logic mem_rd_en;
  logic [7:0] mem_rdata = 8'h00;
  logic [IW-1:0] label_addr;
  logic [3:0] label_rdata = 4'h0;
  logic cnn_rst;
  logic [7:0] cnn_pixel;
  logic cnn_pixel_valid;
  logic [3:0] cnn_decision = 4'h0;
  logic cnn_valid = 1'b0;
  logic busy, done, result_valid, result_correct, timeout_err;
  logic [IW-1:0] result_index, correct_count;
  logic [3:0] result_class;
  always #5 clk = ~clk;
  cnn_frame_sequencer #(
    .IMG_PIXELS(IMG),
    .NUM_IMAGES(NIMG),
    .ADDR_W(AW),
    .IDX_W(IW),
    .CNT_W(10),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata),
    .label_addr(label_addr),
    .label_rdata(label_rdata),
    .cnn_rst(cnn_rst),
    .cnn_pixel(cnn_pixel),
    .cnn_pixel_valid(cnn_pixel_valid),
    .cnn_decision(cnn_decision),
    .cnn_valid(cnn_valid),
    .busy(busy),
    .done(done),
    .result_valid(result_valid),
    .result_index(result_index),
    .result_class(result_class),
    .result_correct(result_correct),
    .correct_count(correct_count),
    .timeout_err(timeout_err)
  );
  typedef struct {
    logic [3:0] label;
    logic [3:0] dec;
    int dly;
    bit never;
    logic [3:0] exp_class;
    bit exp_correct;
    int exp_lat;
  } vec_t;
  typedef struct {
    int idx;
    int cls;
    int cor;
    int lat;
  } res_t;
  vec_t tbl[9];
  int exp_cc[3];
  int exp_terr[3];
  logic [3:0] lbl[4];
  logic [3:0] dec_cfg[NIMG];
  int dly_cfg[NIMG];
  bit nev_cfg[NIMG];
  bit force0 = 1'b0;
  int checks = 0;
  int errors = 0;
  int img_no = -1;
  int pix_seen = 0;
  int rd_k = 0;
  int wcnt = 0;
  int nrst = 0;
  int npix = 0;
  int addr_bad = 0;
  int pix_bad = 0;
  int cyc = 0;
  int last_rd = 0;
  int first_rd = 0;
  int first_pv = 0;
  bit fired = 1'b0;
  logic [AW-1:0] base_seen[NIMG];
  res_t res_q[$];
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? mem_addr[7:0] : 8'h00;
    label_rdata <= lbl[label_addr[1:0]];
  end
  always @(negedge clk) begin
    cnn_valid = 1'b0;
    if (rst) begin
      img_no = -1;
      pix_seen = 0;
      rd_k = 0;
      wcnt = 0;
      fired = 1'b0;
    end else begin
      if (start && !busy) begin
        img_no = -1;
        nrst = 0;
        npix = 0;
        addr_bad = 0;
        pix_bad = 0;
        res_q.delete();
      end
      if (cnn_rst) begin
        img_no++;
        nrst++;
        pix_seen = 0;
        rd_k = 0;
        wcnt = 0;
        fired = 1'b0;
      end
      if (mem_rd_en) begin
        if (img_no == 0 && rd_k == 0) first_rd = cyc;
        if (rd_k == 0 && img_no >= 0 && img_no < NIMG) base_seen[img_no] = mem_addr;
        if (mem_addr != AW'(img_no * IMG + rd_k)) addr_bad++;
        rd_k++;
        last_rd = cyc;
      end
      if (cnn_pixel_valid) begin
        if (img_no == 0 && pix_seen == 0) first_pv = cyc;
        if (cnn_pixel != 8'(img_no * IMG + pix_seen)) pix_bad++;
        pix_seen++;
        npix++;
      end
      if (!cnn_rst && img_no >= 0 && img_no < NIMG) begin
        if (force0 && img_no == 0 && pix_seen < IMG) begin
          cnn_valid = 1'b1;
          cnn_decision = 4'd9;
        end else if (pix_seen == IMG && !fired && !nev_cfg[img_no]) begin
          if (wcnt == dly_cfg[img_no]) begin
            cnn_valid = 1'b1;
            cnn_decision = dec_cfg[img_no];
            fired = 1'b1;
          end
          wcnt++;
        end
      end
      if (result_valid) res_q.push_back('{int'(result_index), int'(result_class), int'(result_correct), cyc - last_rd});
    end
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 5000) begin
      tick();
      n++;
    end
    chk({nm, "_done_in_time"}, 32'(n < 5000), 1);
  endtask
  initial begin
    tbl[0] = '{4'd7, 4'd7, 10, 1'b0, 4'd7, 1'b1, 13};
    tbl[1] = '{4'd2, 4'd3, 10, 1'b0, 4'd3, 1'b0, 13};
    tbl[2] = '{4'd1, 4'd1, 10, 1'b0, 4'd1, 1'b1, 13};
    tbl[3] = '{4'd4, 4'd4, 10, 1'b0, 4'd4, 1'b1, 13};
    tbl[4] = '{4'd5, 4'd5, 0, 1'b1, 4'hF, 1'b0, TO + 1};
    tbl[5] = '{4'd6, 4'd0, 1, 1'b0, 4'd0, 1'b0, 4};
    tbl[6] = '{4'd3, 4'd3, TO - 2, 1'b0, 4'd3, 1'b1, TO + 1};
    tbl[7] = '{4'd8, 4'd8, 1, 1'b0, 4'd8, 1'b1, 4};
    tbl[8] = '{4'd0, 4'd5, 10, 1'b0, 4'd5, 1'b0, 13};
    exp_cc = '{2, 1, 2};
    exp_terr = '{0, 1, 0};
    lbl = '{4'd0, 4'd0, 4'd0, 4'd0};
    repeat (3) tick();
    chk("rst_cnn_rst", 32'(cnn_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_count", 32'(correct_count), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    chk("rst_pix_valid", 32'(cnn_pixel_valid), 0);
    rst = 1'b0;
    tick();
    chk("idle_cnn_rst", 32'(cnn_rst), 0);
    chk("idle_busy", 32'(busy), 0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < NIMG; i++) begin
        lbl[i] = tbl[b * 3 + i].label;
        dec_cfg[i] = tbl[b * 3 + i].dec;
        dly_cfg[i] = tbl[b * 3 + i].dly;
        nev_cfg[i] = tbl[b * 3 + i].never;
      end
      force0 = (b == 0);
      pulse_start();
      chk($sformatf("b%0d_start_busy", b), 32'(busy), 1);
      chk($sformatf("b%0d_start_count_clr", b), 32'(correct_count), 0);
      chk($sformatf("b%0d_start_timeout_clr", b), 32'(timeout_err), 0);
      chk($sformatf("b%0d_start_cnn_rst", b), 32'(cnn_rst), 1);
      if (b == 0) begin
        int n = 0;
        while (!(mem_rd_en && mem_addr == AW'(300)) && n < 1000) begin
          tick();
          n++;
        end
        chk("b0_reach_addr300", 32'(n < 1000), 1);
        pulse_start();
        chk("b0_busy_after_ignored_start", 32'(busy), 1);
        chk("b0_no_restart_addr", 32'(mem_addr), 301);
      end
      wait_done($sformatf("b%0d", b));
      tick();
      chk($sformatf("b%0d_results", b), 32'(res_q.size()), NIMG);
      for (int i = 0; i < NIMG && i < res_q.size(); i++) begin
        chk($sformatf("b%0d_res%0d_index", b, i), 32'(res_q[i].idx), 32'(i));
        chk($sformatf("b%0d_res%0d_class", b, i), 32'(res_q[i].cls), 32'(tbl[b * 3 + i].exp_class));
        chk($sformatf("b%0d_res%0d_correct", b, i), 32'(res_q[i].cor), 32'(tbl[b * 3 + i].exp_correct));
        chk($sformatf("b%0d_res%0d_latency", b, i), 32'(res_q[i].lat), 32'(tbl[b * 3 + i].exp_lat));
        chk($sformatf("b%0d_base%0d", b, i), 32'(base_seen[i]), 32'(i * IMG));
      end
      chk($sformatf("b%0d_correct_count", b), 32'(correct_count), 32'(exp_cc[b]));
      chk($sformatf("b%0d_timeout_err", b), 32'(timeout_err), 32'(exp_terr[b]));
      chk($sformatf("b%0d_done", b), 32'(done), 1);
      chk($sformatf("b%0d_busy", b), 32'(busy), 0);
      chk($sformatf("b%0d_cnn_rst_pulses", b), 32'(nrst), NIMG);
      chk($sformatf("b%0d_pixels", b), 32'(npix), NIMG * IMG);
      chk($sformatf("b%0d_addr_errors", b), 32'(addr_bad), 0);
      chk($sformatf("b%0d_pixel_errors", b), 32'(pix_bad), 0);
      if (b == 0) chk("first_pixel_latency", 32'(first_pv - first_rd), 2);
      repeat (3) tick();
      chk($sformatf("b%0d_done_hold", b), 32'(done), 1);
    end
    force0 = 1'b0;
    for (int i = 0; i < NIMG; i++) begin
      lbl[i] = 4'd0;
      dec_cfg[i] = 4'd0;
      dly_cfg[i] = 10;
      nev_cfg[i] = 1'b0;
    end
    pulse_start();
    begin
      int n = 0;
      while (!(mem_rd_en && mem_addr == AW'(IMG + 400)) && n < 3000) begin
        tick();
        n++;
      end
      chk("d_reach_pixel400", 32'(n < 3000), 1);
    end
    chk("d_count_before_rst", 32'(correct_count), 1);
    chk("d_results_before_rst", 32'(res_q.size()), 1);
    rst = 1'b1;
    tick();
    chk("d_busy", 32'(busy), 0);
    chk("d_rd_en", 32'(mem_rd_en), 0);
    chk("d_cnn_rst", 32'(cnn_rst), 1);
    chk("d_done", 32'(done), 0);
    chk("d_count", 32'(correct_count), 0);
    chk("d_result_valid", 32'(result_valid), 0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("d_cnn_rst_released", 32'(cnn_rst), 0);
    chk("d_idle", 32'(busy), 0);
    chk("d_no_extra_result", 32'(res_q.size()), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
